// File: rtl/t03_wb_pkg.sv
// Shared types and constants for the CPU-to-Wishbone classic-cycle manager.
// Timeout support is selected by the T03_WB_TIMEOUT_EN macro in the files that use it.
package t03_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    localparam logic [31:0] WB_ERR_DATA         = 32'hDEADBEEF;
    localparam int          TIMEOUT_CYCLES_DFLT = 255;

endpackage

// File: rtl/t03_wb_timeout_ctr.sv
// Cycle counter for bus-cycle timeout; expired_o flags the LIMIT-th enabled cycle.
// Instantiated by t03_wb_manager only when T03_WB_TIMEOUT_EN is defined.
module t03_wb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: cleared outside the bus cycle, saturating once at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The first bus cycle sees a count of zero, so LIMIT-1 marks the LIMIT-th cycle.
    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/t03_wb_manager.sv
// Converts the CPU's level-held read/write request into Wishbone B4 classic single cycles.
// Define T03_WB_TIMEOUT_EN to abort bus cycles that see no ACK_I within TIMEOUT_CYCLES.
module t03_wb_manager
    import t03_wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_sel,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic [3:0]        SEL_O,
    output logic              WE_O,
    output logic              STB_O,
    output logic              CYC_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I
);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              expired_s;

`ifdef T03_WB_TIMEOUT_EN
    t03_wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != BUS),
        .en_i      (state_q == BUS),
        .expired_o (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state and registered-output logic; ACK_I outside BUS has no effect.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_write || cpu_read) begin
                    adr_d   = cpu_addr;
                    dat_d   = cpu_wdata;
                    sel_d   = cpu_sel;
                    we_d    = cpu_write;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end else begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (ACK_I) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = DAT_I;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (expired_s) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(WB_ERR_DATA);
                    state_d = DONE;
                end else begin
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            // Bubble so the still-held request level is not re-issued.
            DONE: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= {ADDR_W{1'b0}};
            dat_q   <= {DATA_W{1'b0}};
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;
    assign WE_O      = we_q;
    assign CYC_O     = cyc_q;
    assign STB_O     = cyc_q;
    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign busy      = busy_q;

endmodule
